scan_code_sequencer: RTL and testbench

Sequences raw PS/2 keyboard bytes into complete key events. Sits directly after the byte receiver (`ready` strobe plus `datain` byte). It tracks the E0 (extended), F0 (break) and E1 (Pause) prefix sequences and discards controller/status bytes. Each finished key event is pushed into a small show-ahead FIFO, which the consumer drains with a valid/pop handshake.

---
 rtl/scan_code_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_scan_code_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/scan_code_sequencer.sv
// scan_code_sequencer: turns raw PS/2 bytes (E0/F0/E1 prefixed) into key
// events and queues them in a small show-ahead FIFO for the consumer.
module scan_code_sequencer #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned ADDR_W      = 2,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready,
  input  logic [7:0]        datain,
  input  logic              evt_pop,
  input  logic              clr_ovf,
  output logic              evt_valid,
  output logic [7:0]        evt_code,
  output logic              evt_ext,
  output logic              evt_break,
  output logic              overflow,
  output logic              busy,
  output logic [ADDR_W:0]   fifo_count
);

  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned SKIP_W = 3;

  localparam logic [7:0]        BYTE_E0    = 8'hE0;
  localparam logic [7:0]        BYTE_F0    = 8'hF0;
  localparam logic [7:0]        BYTE_E1    = 8'hE1;
  localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(FIFO_DEPTH);
  localparam logic [SKIP_W-1:0] PAUSE_SKIP = SKIP_W'(7);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_PAUSE
  } state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } evt_t;

  // Sequencer state
  state_t              state;
  logic                ext_q;
  logic [SKIP_W-1:0]   skip_q;
  logic [TMO_W-1:0]    tmo_q;

  // FIFO state
  evt_t                mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]    count_q;

  // Combinational helpers
  logic                is_prefix_c;
  logic                is_status_c;
  logic                push_c;
  evt_t                push_evt_c;
  logic                pop_c;
  logic                full_c;
  logic                wr_en_c;
  logic                drop_c;
  evt_t                head_c;

  // Byte classification: sequence prefixes and controller/status bytes
  always_comb begin
    is_prefix_c = (datain == BYTE_E0) || (datain == BYTE_F0) || (datain == BYTE_E1);
    is_status_c = datain inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
  end

  // Event completion decode; the push lands in the FIFO on the same edge
  always_comb begin
    push_c     = 1'b0;
    push_evt_c = '0;
    if (ready) begin
      unique case (state)
        ST_IDLE: begin
          if (!is_prefix_c && !is_status_c) begin
            push_c     = 1'b1;
            push_evt_c = '{code: datain, ext: 1'b0, brk: 1'b0};
          end
        end
        ST_EXT: begin
          if (!is_prefix_c && !is_status_c) begin
            push_c     = 1'b1;
            push_evt_c = '{code: datain, ext: 1'b1, brk: 1'b0};
          end
        end
        ST_BRK: begin
          if (!is_prefix_c && !is_status_c) begin
            push_c     = 1'b1;
            push_evt_c = '{code: datain, ext: ext_q, brk: 1'b1};
          end
        end
        ST_PAUSE: begin
          if (skip_q == SKIP_W'(1)) begin
            push_c     = 1'b1;
            push_evt_c = '{code: BYTE_E1, ext: 1'b0, brk: 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  // Prefix sequencer with inter-byte timeout; a strobe beats the timeout
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      ext_q  <= 1'b0;
      skip_q <= '0;
      tmo_q  <= '0;
    end else if (ready) begin
      tmo_q <= '0;
      unique case (state)
        ST_IDLE: begin
          if (datain == BYTE_E0) begin
            state <= ST_EXT;
            busy  <= 1'b1;
          end else if (datain == BYTE_F0) begin
            state <= ST_BRK;
            busy  <= 1'b1;
            ext_q <= 1'b0;
          end else if (datain == BYTE_E1) begin
            state  <= ST_PAUSE;
            busy   <= 1'b1;
            skip_q <= PAUSE_SKIP;
          end
        end
        ST_EXT: begin
          if (datain == BYTE_F0) begin
            state <= ST_BRK;
            busy  <= 1'b1;
            ext_q <= 1'b1;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_BRK: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        ST_PAUSE: begin
          skip_q <= skip_q - SKIP_W'(1);
          if (skip_q == SKIP_W'(1)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end else if (state != ST_IDLE) begin
      if (tmo_q == TMO_LAST) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
        tmo_q <= '0;
      end else begin
        tmo_q <= tmo_q + TMO_W'(1);
      end
    end else begin
      tmo_q <= '0;
    end
  end

  // FIFO control: a pop frees a slot for a simultaneous push even when full
  always_comb begin
    pop_c   = evt_pop && (count_q != '0);
    full_c  = (count_q == CNT_FULL);
    wr_en_c = push_c && (!full_c || pop_c);
    drop_c  = push_c && full_c && !pop_c;
  end

  // FIFO storage; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[wr_ptr] <= push_evt_c;
    end
  end

  // FIFO pointers, occupancy and sticky overflow (set beats clear)
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en_c) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      unique case ({wr_en_c, pop_c})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (drop_c) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  // Show-ahead head view, forced to zero while empty
  always_comb begin
    head_c     = mem[rd_ptr];
    evt_valid  = (count_q != '0);
    fifo_count = count_q;
    evt_code   = evt_valid ? head_c.code : 8'h00;
    evt_ext    = evt_valid && head_c.ext;
    evt_break  = evt_valid && head_c.brk;
  end

endmodule

// File: tb/tb_scan_code_sequencer.sv
// Directed bench for scan_code_sequencer with a queue-based event scoreboard.
module tb_scan_code_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;
  localparam int unsigned TMO   = 40;

  logic          clk;
  logic          reset;
  logic          ready;
  logic [7:0]    datain;
  logic          evt_pop;
  logic          clr_ovf;
  logic          evt_valid;
  logic [7:0]    evt_code;
  logic          evt_ext;
  logic          evt_break;
  logic          overflow;
  logic          busy;
  logic [AW:0]   fifo_count;

  logic [9:0]    exp_q[$];
  int            tests;
  int            fails;

  scan_code_sequencer #(
    .FIFO_DEPTH (DEPTH),
    .ADDR_W     (AW),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ready     (ready),
    .datain    (datain),
    .evt_pop   (evt_pop),
    .clr_ovf   (clr_ovf),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .evt_ext   (evt_ext),
    .evt_break (evt_break),
    .overflow  (overflow),
    .busy      (busy),
    .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_evt(input logic [7:0] code, input logic ext, input logic brk);
    exp_q.push_back({code, ext, brk});
  endtask

  // One-cycle strobe; returns at the negedge after the consuming posedge
  task automatic send(input logic [7:0] b);
    ready  = 1'b1;
    datain = b;
    @(negedge clk);
    ready  = 1'b0;
    datain = 8'h00;
  endtask

  // Compare the head event against the scoreboard, then pop it
  task automatic pop_check(input string tag);
    logic [9:0] exp;
    exp = 10'h000;
    if (exp_q.size() != 0) exp = exp_q.pop_front();
    check({tag, "_valid"}, 32'(evt_valid), 32'd1);
    check({tag, "_evt"}, 32'({evt_code, evt_ext, evt_break}), 32'(exp));
    evt_pop = 1'b1;
    @(negedge clk);
    evt_pop = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, 32'({evt_valid, evt_code, evt_ext, evt_break, overflow, busy, fifo_count}), 32'd0);
  endtask

  initial begin
    logic [9:0] exp;
    tests   = 0;
    fails   = 0;
    reset   = 1'b1;
    ready   = 1'b0;
    datain  = 8'h00;
    evt_pop = 1'b0;
    clr_ovf = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset_state");
    reset = 1'b0;
    @(negedge clk);

    // Single make code, then pop empties the FIFO
    send(8'h1C);
    expect_evt(8'h1C, 1'b0, 1'b0);
    check("make_count", 32'(fifo_count), 32'd1);
    pop_check("make");
    check("make_empty", 32'({evt_valid, fifo_count}), 32'd0);

    // Break and extended break, back-to-back strobes
    send(8'hF0);
    check("brk_busy", 32'(busy), 32'd1);
    send(8'h1C);
    expect_evt(8'h1C, 1'b0, 1'b1);
    check("brk_idle", 32'(busy), 32'd0);
    send(8'hE0);
    send(8'hF0);
    check("extbrk_busy", 32'(busy), 32'd1);
    send(8'h75);
    expect_evt(8'h75, 1'b1, 1'b1);
    check("two_count", 32'(fifo_count), 32'd2);
    pop_check("brk1");
    pop_check("brk2");

    // Pause sequence: one E1 event only after the 8th byte
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0);
    check("pause_pending", 32'({busy, fifo_count}), 32'({1'b1, 3'd0}));
    send(8'h77);
    expect_evt(8'hE1, 1'b0, 1'b0);
    check("pause_done", 32'({busy, fifo_count}), 32'({1'b0, 3'd1}));
    pop_check("pause");

    // Status byte in IDLE is dropped; E0 followed by status aborts
    send(8'hFA);
    check("status_drop", 32'({busy, fifo_count}), 32'd0);
    send(8'hE0);
    send(8'hAA);
    check("ext_abort", 32'({busy, fifo_count}), 32'd0);

    // Overflow: fifth push into a depth-4 FIFO is dropped
    send(8'h15); expect_evt(8'h15, 1'b0, 1'b0);
    send(8'h1D); expect_evt(8'h1D, 1'b0, 1'b0);
    send(8'h24); expect_evt(8'h24, 1'b0, 1'b0);
    send(8'h2D); expect_evt(8'h2D, 1'b0, 1'b0);
    check("full_no_ovf", 32'({overflow, fifo_count}), 32'({1'b0, 3'd4}));
    send(8'h2C);
    check("ovf_set", 32'({overflow, fifo_count}), 32'({1'b1, 3'd4}));

    // Push and pop in the same cycle while full keeps the count at 4
    exp = exp_q.pop_front();
    check("full_head", 32'({evt_code, evt_ext, evt_break}), 32'(exp));
    expect_evt(8'h35, 1'b0, 1'b0);
    ready   = 1'b1;
    datain  = 8'h35;
    evt_pop = 1'b1;
    @(negedge clk);
    ready   = 1'b0;
    datain  = 8'h00;
    evt_pop = 1'b0;
    check("pushpop_full", 32'({overflow, fifo_count}), 32'({1'b1, 3'd4}));
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    check("ovf_clear", 32'(overflow), 32'd0);
    pop_check("drain1");
    pop_check("drain2");
    pop_check("drain3");
    pop_check("drain4");
    check("drained", 32'(fifo_count), 32'd0);

    // Timeout after E0: busy holds through TMO-1 idle cycles, then drops
    send(8'hE0);
    repeat (TMO - 1) @(negedge clk);
    check("tmo_edge_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("tmo_idle", 32'(busy), 32'd0);
    send(8'h75);
    expect_evt(8'h75, 1'b0, 1'b0);
    pop_check("after_tmo");

    // Strobe on the timeout cycle wins: sequence continues as extended
    send(8'hE0);
    repeat (TMO - 1) @(negedge clk);
    send(8'h74);
    expect_evt(8'h74, 1'b1, 1'b0);
    pop_check("tmo_strobe_prio");

    // Reset mid-sequence with a queued event: everything cleared
    send(8'h16);
    send(8'hF0);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("midseq_reset");
    reset = 1'b0;
    exp_q.delete();
    send(8'h1C);
    expect_evt(8'h1C, 1'b0, 1'b0);
    pop_check("post_reset");

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("final_empty", 32'({evt_valid, fifo_count, busy}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
